// File: rtl/bcd_convert_param.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// The add-3 correction and the shift happen in one cycle, so a conversion
// takes BIN_WIDTH cycles. Optional two's-complement input is converted as
// sign plus magnitude. The result ports only change on the done pulse.
module bcd_convert_param #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int CMP_W = (BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W;

  // 10^DIGITS - 1. 10^DIGITS < 16^DIGITS, so CMP_W bits always hold it.
  function automatic logic [CMP_W-1:0] max_value();
    logic [CMP_W-1:0] v;
    v = CMP_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      v = (v << 3) + (v << 1);
    end
    return v - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL = max_value();
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]     work_q, work_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  // Sign and overflow of the operand in flight; published on done.
  logic                 sign_pend_q, sign_pend_d;
  logic                 ovf_pend_q, ovf_pend_d;

  logic [BCD_W-1:0]     work_adj;
  logic [BCD_W-1:0]     work_shift;
  logic [BIN_WIDTH-1:0] mag_load;
  logic                 neg_load;
  logic                 ovf_load;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                 work_q[4*gi +: 4] + 4'd3 : work_q[4*gi +: 4];
  end

  // Bit leaving the top digit is dropped, which yields magnitude mod 10^DIGITS.
  assign work_shift = {work_adj[BCD_W-2:0], mag_q[BIN_WIDTH-1]};

  // Most negative operand negates to itself, which reads correctly as unsigned.
  assign neg_load = SIGNED && binary[BIN_WIDTH-1];
  assign mag_load = neg_load ? (~binary + BIN_WIDTH'(1)) : binary;
  assign ovf_load = CMP_W'(mag_load) > MAX_VAL;

  // Next-state and datapath control; everything holds unless updated below.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    sign_pend_d = sign_pend_q;
    ovf_pend_d  = ovf_pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d       = mag_load;
          sign_pend_d = neg_load;
          ovf_pend_d  = ovf_load;
          work_d      = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_shift;
        mag_d  = {mag_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_d   = work_shift;
          sign_d  = sign_pend_q;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sign_pend_q <= 1'b0;
      ovf_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      sign_pend_q <= sign_pend_d;
      ovf_pend_q  <= ovf_pend_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_convert_param.sv
// Bench for bcd_convert_param: a default instance (14 bit, 4 digits,
// unsigned) and a signed 8 bit / 3 digit instance, checked every cycle
// against an arithmetic model plus directed literal expectations.
module tb_bcd_convert_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic [13:0] bin_a = '0;
  logic        busy_a, done_a, sign_a, ovf_a;
  logic [15:0] bcd_a;
  logic        start_b = 1'b0;
  logic [7:0]  bin_b = '0;
  logic        busy_b, done_b, sign_b, ovf_b;
  logic [11:0] bcd_b;

  int errors = 0;
  int checks = 0;

  bcd_convert_param #(.BIN_WIDTH(14), .DIGITS(4), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .sign(sign_a), .overflow(ovf_a)
  );

  bcd_convert_param #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .sign(sign_b), .overflow(ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result from plain arithmetic: magnitude, mod 10^d, decimal digits.
  typedef struct packed {
    logic [15:0] bcd;
    logic        sign;
    logic        ovf;
  } res_t;

  function automatic res_t calc(input int w, input int d, input int s, input int unsigned v);
    res_t r;
    int unsigned mag, lim, rem;
    bit neg;
    neg = (s != 0) && (((v >> (w - 1)) & 1) == 1);
    mag = neg ? ((32'd1 << w) - v) : v;
    lim = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    r.ovf  = (mag > lim - 1);
    r.sign = neg;
    rem    = mag % lim;
    r.bcd  = '0;
    for (int k = 0; k < d; k++) begin
      r.bcd[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  // Model: an accepted operand yields its result exactly W cycles later.
  logic m_busy[2];
  logic m_done[2];
  int   m_left[2];
  res_t m_out[2];
  res_t m_pend[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_left[i] <= 0;
        m_out[i]  <= '0;
        m_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if ((i == 0) ? start_a : start_b) begin
            m_pend[i] <= (i == 0) ? calc(14, 4, 0, 32'(bin_a)) : calc(8, 3, 1, 32'(bin_b));
            m_busy[i] <= 1'b1;
            m_left[i] <= (i == 0) ? 14 : 8;
          end
        end else if (m_left[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_out[i]  <= m_pend[i];
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a_busy", 32'(busy_a), 32'(m_busy[0]));
    chk("a_done", 32'(done_a), 32'(m_done[0]));
    chk("a_bcd",  32'(bcd_a),  32'(m_out[0].bcd));
    chk("a_sign", 32'(sign_a), 32'(m_out[0].sign));
    chk("a_ovf",  32'(ovf_a),  32'(m_out[0].ovf));
    chk("b_busy", 32'(busy_b), 32'(m_busy[1]));
    chk("b_done", 32'(done_b), 32'(m_done[1]));
    chk("b_bcd",  32'({4'b0, bcd_b}), 32'(m_out[1].bcd));
    chk("b_sign", 32'(sign_b), 32'(m_out[1].sign));
    chk("b_ovf",  32'(ovf_b),  32'(m_out[1].ovf));
  end

  // One-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input int id, input int unsigned v);
    @(negedge clk);
    if (id == 0) begin
      start_a = 1'b1;
      bin_a   = 14'(v);
    end else begin
      start_b = 1'b1;
      bin_b   = 8'(v);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a   = 14'($urandom);
    bin_b   = 8'($urandom);
  endtask

  task automatic wait_done(input int id, output int n);
    n = 0;
    while (!((id == 0) ? done_a : done_b) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done on instance %0d after %0d cycles", id, n);
    end
  endtask

  task automatic count_dones(input int cycles, output int k);
    k = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_a) k++;
    end
  endtask

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_bcd",  32'(bcd_a), 0);
    chk("rst_ovf",  32'(ovf_a), 0);
    rst_n = 1'b1;

    // 9999: 14 cycle latency, no overflow
    issue(0, 9999);
    chk("t1_busy", 32'(busy_a), 1);
    wait_done(0, n);
    chk("t1_lat", 32'(n), 14);
    chk("t1_bcd", 32'(bcd_a), 32'h9999);
    chk("t1_ovf", 32'(ovf_a), 0);
    chk("t1_busy_done", 32'(busy_a), 0);
    $display("txn 9999 -> bcd=%h ovf=%0d", bcd_a, ovf_a);

    // 0 then 1 started in the done cycle
    issue(0, 0);
    wait_done(0, n);
    chk("t2_bcd0", 32'(bcd_a), 32'h0000);
    $display("txn 0 -> bcd=%h", bcd_a);
    start_a = 1'b1;
    bin_a   = 14'd1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, n);
    chk("t2_lat", 32'(n), 14);
    chk("t2_bcd1", 32'(bcd_a), 32'h0001);
    $display("txn 1 (back-to-back) -> bcd=%h", bcd_a);

    // 16383 overflows four digits
    issue(0, 16383);
    wait_done(0, n);
    chk("t3_ovf", 32'(ovf_a), 1);
    chk("t3_bcd", 32'(bcd_a), 32'h6383);
    chk("t3_sign", 32'(sign_a), 0);
    $display("txn 16383 -> bcd=%h ovf=%0d", bcd_a, ovf_a);

    // Signed 8-bit, 3 digits
    issue(1, 32'h80);
    wait_done(1, n);
    chk("t4_lat", 32'(n), 8);
    chk("t4_80_sign", 32'(sign_b), 1);
    chk("t4_80_bcd", 32'(bcd_b), 32'h128);
    $display("txn 8'h80 -> sign=%0d bcd=%h", sign_b, bcd_b);
    issue(1, 32'hFF);
    wait_done(1, n);
    chk("t4_ff_sign", 32'(sign_b), 1);
    chk("t4_ff_bcd", 32'(bcd_b), 32'h001);
    $display("txn 8'hFF -> sign=%0d bcd=%h", sign_b, bcd_b);
    issue(1, 32'h7F);
    wait_done(1, n);
    chk("t4_7f_sign", 32'(sign_b), 0);
    chk("t4_7f_bcd", 32'(bcd_b), 32'h127);
    $display("txn 8'h7F -> sign=%0d bcd=%h", sign_b, bcd_b);

    // start while busy is ignored
    issue(0, 1234);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    bin_a   = 14'd5678;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, n);
    chk("t5_lat", 32'(n + 5), 14);
    chk("t5_bcd", 32'(bcd_a), 32'h1234);
    count_dones(20, k);
    chk("t5_extra_done", 32'(k), 0);
    $display("txn 1234 (5678 ignored) -> bcd=%h", bcd_a);

    // Reset mid-conversion
    issue(0, 777);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_done", 32'(done_a), 0);
    chk("t6_bcd", 32'(bcd_a), 0);
    chk("t6_sign", 32'(sign_a), 0);
    chk("t6_ovf", 32'(ovf_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dones(20, k);
    chk("t6_no_done", 32'(k), 0);
    issue(0, 42);
    wait_done(0, n);
    chk("t6_bcd42", 32'(bcd_a), 32'h0042);
    $display("txn reset-abort then 42 -> bcd=%h", bcd_a);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
